// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//
// Avalon-MM read master that interrogates a system-ID slave and compares its
// two words against build-time constants. A check reads the ID word at
// BASE_ADDR, then the timestamp word at BASE_ADDR+4. It then latches both
// values together with pass/fail flags. A check is launched by a single-cycle
// start pulse, or automatically after reset release when AUTO_START=1.
//
// Parameters
//   BASE_ADDR       byte address of the system-ID slave
//   EXPECTED_ID     required ID word
//   EXPECTED_TS     required timestamp word
//   TIMEOUT_CYCLES  max consecutive stalled cycles per read (0 = no timeout)
//   AUTO_START      1 = run one check straight out of reset
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            single-cycle request to run a check
//   avm_address      byte address of the current read (registered)
//   avm_read         read strobe (registered)
//   avm_waitrequest  slave/fabric stall
//   avm_readdata     read data, valid when avm_read && !avm_waitrequest
//   busy             check in progress
//   done             check finished, held until the next check starts
//   id_ok / ts_ok    captured words equal the expected constants
//   timeout          last check aborted on a waitrequest timeout
//   id_value         captured ID word
//   ts_value         captured timestamp word
// -----------------------------------------------------------------------------
module sysid_checker #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'd469964199,
    parameter logic [31:0] EXPECTED_TS    = 32'd1329011361,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_DONE
    } state_t;

    // With AUTO_START the machine comes out of reset already issuing the ID read.
    localparam state_t      RESET_STATE  = AUTO_START ? S_RD_ID : S_IDLE;
    localparam logic [31:0] TS_ADDR      = BASE_ADDR + 32'd4;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // The counter holds the number of stalls already seen. The abort therefore
    // fires on the stalled edge where TIMEOUT_CYCLES-1 stalls have gone before.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q;
    logic        read_q;
    logic [31:0] addr_q;
    logic        busy_q;
    logic        done_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        timeout_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic [7:0]  wait_cnt_q;

    logic [7:0]  wait_cnt_d;
    logic        stall_abort;

    assign wait_cnt_d  = wait_cnt_q + 8'd1;
    assign stall_abort = TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST);

    // NOTE: every register is assigned with <= and reset asynchronously, so all
    // outputs snap to their reset values the moment reset_n falls, even mid-read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            read_q     <= AUTO_START;
            addr_q     <= BASE_ADDR;
            busy_q     <= AUTO_START;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Captured words are kept until they are overwritten by the new check.
                    if (start) begin
                        state_q    <= S_RD_ID;
                        read_q     <= 1'b1;
                        addr_q     <= BASE_ADDR;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        id_ok_q    <= 1'b0;
                        ts_ok_q    <= 1'b0;
                        timeout_q  <= 1'b0;
                        wait_cnt_q <= '0;
                    end
                end

                S_RD_ID, S_RD_TS: begin
                    // A stall leaves read_q/addr_q untouched, which keeps the
                    // Avalon command stable. A start pulse here is ignored.
                    if (!avm_waitrequest) begin
                        wait_cnt_q <= '0;
                        if (state_q == S_RD_ID) begin
                            id_value_q <= avm_readdata;
                            addr_q     <= TS_ADDR;
                            state_q    <= S_RD_TS;
                        end else begin
                            ts_value_q <= avm_readdata;
                            id_ok_q    <= (id_value_q == EXPECTED_ID);
                            ts_ok_q    <= (avm_readdata == EXPECTED_TS);
                            done_q     <= 1'b1;
                            read_q     <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end else if (stall_abort) begin
                        // Abort: the pending read's capture register is left as it was.
                        wait_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        id_ok_q    <= 1'b0;
                        ts_ok_q    <= 1'b0;
                        read_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that interrogates a system-ID slave and checks its two words against build-time constants. After reset (optionally) or on a `start` pulse it reads the ID word at `BASE_ADDR` and the timestamp word at `BASE_ADDR+4`, then latches both values and pass/fail flags. It sits beside the CPU in the SOPC system as a hardware self-check, driving status LEDs and gating software boot on a matching image.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the system-ID slave (word 0 = ID, word 1 = timestamp)
- `EXPECTED_ID`, 32'd469964199, required ID word
- `EXPECTED_TS`, 32'd1329011361, required timestamp word
- `TIMEOUT_CYCLES`, 255, maximum consecutive `avm_waitrequest` cycles per read; 0 disables the timeout; 8-bit counter range (1..255)
- `AUTO_START`, 1, 1 = launch one check automatically after reset release

- `clk` input 1 system clock; all logic on rising edge
- `reset_n` input 1 asynchronous, active-low reset
- `start` input 1 single-cycle request to run a check
- `avm_address` output 32 byte address of the current read
- `avm_read` output 1 Avalon read strobe
- `avm_waitrequest` input 1 slave/fabric stall
- `avm_readdata` input 32 read data, valid when `avm_read && !avm_waitrequest`
- `busy` output 1 check in progress
- `done` output 1 check finished; held until the next check starts
- `id_ok` output 1 captured ID equals `EXPECTED_ID`
- `ts_ok` output 1 captured timestamp equals `EXPECTED_TS`
- `timeout` output 1 last check aborted on waitrequest timeout
- `id_value` output 32 captured ID word
- `ts_value` output 32 captured timestamp word

## Operation
- States: IDLE, RD_ID, RD_TS, DONE. Reset state is IDLE when `AUTO_START`=0, RD_ID when `AUTO_START`=1.
- Reset values: `avm_read`=0 (1 in RD_ID when `AUTO_START`=1), `avm_address`=`BASE_ADDR`, `busy`=`AUTO_START`, `done`=`id_ok`=`ts_ok`=`timeout`=0, `id_value`=`ts_value`=0, wait counter 0.
- IDLE/DONE + `start`=1 → RD_ID; on that edge clear `done`, `id_ok`, `ts_ok`, `timeout`; `id_value`/`ts_value` keep their old contents until overwritten.
- RD_ID: `avm_read`=1, `avm_address`=`BASE_ADDR`. On an edge with `avm_waitrequest`=0: `id_value`←`avm_readdata`, → RD_TS.
- RD_TS: `avm_read`=1, `avm_address`=`BASE_ADDR+4`. On accept: `ts_value`←`avm_readdata`, `id_ok`←(`id_value`==`EXPECTED_ID`), `ts_ok`←(`avm_readdata`==`EXPECTED_TS`), `done`←1, → DONE.
- `avm_read` and `avm_address` are registered and held constant while `avm_waitrequest`=1 (Avalon stall rule). `avm_read` is 0 in IDLE and DONE.
- `busy`=1 exactly in RD_ID and RD_TS.
- Timeout: the wait counter increments on each read-state cycle with `avm_waitrequest`=1 and clears on accept or state change. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1 on a stalled edge → DONE with `timeout`=1, `done`=1, `id_ok`=`ts_ok`=0, `avm_read`=0. The captured value of the aborted read is not updated.
- `start` during RD_ID/RD_TS is ignored (no restart, no queueing).
- `reset_n` low mid-read drops `avm_read` asynchronously and returns to the reset state.

## Timing
- Zero-wait slave, `start` sampled at edge k: `avm_read` is high for cycles k+1 and k+2 (ID address, then timestamp address); `done`/`id_ok`/`ts_ok` are valid after edge k+2. Total latency is 2 cycles plus the stall cycles.
- Each stall cycle extends the current read by one cycle.
- With a timeout, the abort takes effect after exactly `TIMEOUT_CYCLES` consecutive stalled read cycles.
- Comparisons are full 32-bit equality. No arithmetic widths beyond the 8-bit wait counter and `BASE_ADDR+4` (32-bit, wraps modulo 2^32).

## Test plan
- `AUTO_START`=1, zero-wait slave returning 469964199 / 1329011361 → after reset release, two reads at 0x0 then 0x4, then `done`=1, `id_ok`=`ts_ok`=1, `busy`=0 at the third edge.
- ID slave returns 0xDEADBEEF for word 0 → `id_ok`=0, `ts_ok`=1, `id_value`=0xDEADBEEF.
- Waitrequest held for 3 cycles on each read → `avm_address`/`avm_read` are stable throughout; done latency is 2+6 cycles; both flags are 1.
- `TIMEOUT_CYCLES`=4, waitrequest stuck high → after 4 stalled cycles, `timeout`=1, `done`=1, ok flags 0, `avm_read`=0.
- `start` pulsed during RD_TS, then again in DONE → first pulse is ignored; second clears `done` and the flags and reruns the check.
- `reset_n` asserted mid-stall in RD_TS → outputs return to their reset values immediately; with `AUTO_START`=0, no read occurs until `start`.
